wb_regfile_mc: RTL and testbench

WB_REGFILE_MC -- requirements
Module: wb_regfile_mc

---
 rtl/wb_regfile_mc.sv | 104 ++++++++++
 tb/tb_wb_regfile_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_mc.sv
// Wishbone register file: N_CH channels of {ctrl, period, divisor, dc}, single-cycle ack/err.
// Optional lock feature enabled by defining WB_REGFILE_LOCK_EN (ctrl[DW-1] locks the channel).
module wb_regfile_mc #(
    parameter int N_CH = 3,
    parameter int DW   = 16,
    parameter int AW   = 16
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst_n,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [AW-1:0]      i_wb_adr,
    input  logic [DW/8-1:0]    i_wb_sel,
    input  logic [DW-1:0]      i_wb_data,
    output logic               o_wb_ack,
    output logic               o_wb_err,
    output logic [DW-1:0]      o_wb_data,
    output logic [N_CH*DW-1:0] o_ctrl,
    output logic [N_CH*DW-1:0] o_period,
    output logic [N_CH*DW-1:0] o_divisor,
    output logic [N_CH*DW-1:0] o_dc,
    output logic [N_CH-1:0]    o_cfg_upd
);

    localparam int NREG = 4 * N_CH;
    localparam int NB   = DW / 8;

    logic [DW-1:0]   regs_r [NREG];
    logic            ack_r;
    logic            err_r;
    logic [DW-1:0]   rdata_r;
    logic [N_CH-1:0] upd_r;

    logic            accept_s;
    logic            valid_s;
    logic            lock_s;
    logic            ok_s;
    logic            commit_s;
    logic [DW-1:0]   rd_word_s;

    // Request decode: address validity, lock check, and read mux.
    always_comb begin
        accept_s  = i_wb_cyc & i_wb_stb & ~ack_r & ~err_r;
        valid_s   = (i_wb_adr < AW'(NREG));
        rd_word_s = '0;
        lock_s    = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            rd_word_s = (i_wb_adr == AW'(r)) ? regs_r[r] : rd_word_s;
        end
`ifdef WB_REGFILE_LOCK_EN
        for (int c = 0; c < N_CH; c++) begin
            lock_s = (i_wb_adr[AW-1:2] == (AW-2)'(c)) ? regs_r[4*c][DW-1] : lock_s;
        end
        // ctrl itself stays writable so software can clear the lock
        lock_s = lock_s & (i_wb_adr[1:0] != 2'd0);
`endif
        ok_s     = valid_s & ~(i_wb_we & lock_s);
        commit_s = accept_s & ok_s & i_wb_we;
    end

    // Register storage, bus response and update strobes.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_r[r] <= '0;
            end
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= '0;
            upd_r   <= '0;
        end else begin
            ack_r   <= accept_s & ok_s;
            err_r   <= accept_s & ~ok_s;
            rdata_r <= (accept_s & ok_s & ~i_wb_we) ? rd_word_s : '0;
            for (int r = 0; r < NREG; r++) begin
                if (commit_s && (i_wb_adr == AW'(r))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (i_wb_sel[b]) begin
                            regs_r[r][8*b +: 8] <= i_wb_data[8*b +: 8];
                        end
                    end
                end
            end
            // strobe fires even for sel=0 writes: the commit itself is the event
            for (int c = 0; c < N_CH; c++) begin
                upd_r[c] <= commit_s & (i_wb_adr[AW-1:2] == (AW-2)'(c));
            end
        end
    end

    assign o_wb_ack  = ack_r;
    assign o_wb_err  = err_r;
    assign o_wb_data = rdata_r;
    assign o_cfg_upd = upd_r;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign o_ctrl   [c*DW +: DW] = regs_r[4*c + 0];
        assign o_period [c*DW +: DW] = regs_r[4*c + 1];
        assign o_divisor[c*DW +: DW] = regs_r[4*c + 2];
        assign o_dc     [c*DW +: DW] = regs_r[4*c + 3];
    end

endmodule

// File: tb/tb_wb_regfile_mc.sv
// Scoreboard bench for wb_regfile_mc (N_CH=3, DW=16); follows WB_REGFILE_LOCK_EN if defined.
module tb_wb_regfile_mc;

    localparam int N_CH = 3;
    localparam int DW   = 16;
    localparam int AW   = 16;
`ifdef WB_REGFILE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cyc = 1'b0;
    logic               stb = 1'b0;
    logic               we = 1'b0;
    logic [AW-1:0]      adr = '0;
    logic [1:0]         sel = '0;
    logic [DW-1:0]      wdata = '0;
    logic               ack;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [N_CH*DW-1:0] ctrl, period, divisor, dc;
    logic [N_CH-1:0]    upd;

    typedef struct {
        logic            ack;
        logic            err;
        logic [DW-1:0]   data;
        logic [N_CH-1:0] upd;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [4*N_CH];
    int            vectors = 0;
    int            miscompares = 0;

    wb_regfile_mc #(.N_CH(N_CH), .DW(DW), .AW(AW)) dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_data(wdata),
        .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata),
        .o_ctrl(ctrl), .o_period(period), .o_divisor(divisor), .o_dc(dc),
        .o_cfg_upd(upd)
    );

    always #5 clk = ~clk;

    // Predict the response to the currently driven request and update the model.
    task automatic predict();
        exp_t e;
        int   a = int'(adr);
        bit   valid = (a < 4*N_CH);
        bit   locked = 1'b0;
        if (valid && LOCK && (a % 4 != 0)) locked = model[(a/4)*4][DW-1];
        e.ack  = valid && !(we && locked);
        e.err  = !e.ack;
        e.data = (e.ack && !we) ? model[a] : '0;
        e.upd  = (e.ack && we) ? N_CH'(1 << (a/4)) : '0;
        if (e.ack && we) begin
            if (sel[0]) model[a][7:0]  = wdata[7:0];
            if (sel[1]) model[a][15:8] = wdata[15:8];
        end
        sb.push_back(e);
    endtask

    task automatic check_channels(input string tag);
        logic [N_CH*DW-1:0] ec, ep, ed, ew;
        for (int c = 0; c < N_CH; c++) begin
            ec[c*DW +: DW] = model[4*c];
            ep[c*DW +: DW] = model[4*c+1];
            ed[c*DW +: DW] = model[4*c+2];
            ew[c*DW +: DW] = model[4*c+3];
        end
        vectors++;
        if ({ctrl, period, divisor, dc} !== {ec, ep, ed, ew}) begin
            miscompares++;
            $display("FAIL %s channels: got %h/%h/%h/%h expected %h/%h/%h/%h",
                     tag, ctrl, period, divisor, dc, ec, ep, ed, ew);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if ({ack, err, rdata, upd} !== {e.ack, e.err, e.data, e.upd}) begin
            miscompares++;
            $display("FAIL %s: got ack=%b err=%b data=%h upd=%b expected ack=%b err=%b data=%h upd=%b",
                     tag, ack, err, rdata, upd, e.ack, e.err, e.data, e.upd);
        end
    endtask

    // One bus transfer: request for one edge, drop stb in the response cycle, then idle.
    task automatic bus(input string tag, input logic w, input int a, input logic [1:0] s,
                       input logic [DW-1:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(a); sel = s; wdata = d;
        predict();
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        pop_compare(tag);
        check_channels(tag);
        @(posedge clk); #1;
        vectors++;
        if ({ack, err, rdata, upd} !== '0) begin
            miscompares++;
            $display("FAIL %s idle: got ack=%b err=%b data=%h upd=%b expected all 0",
                     tag, ack, err, rdata, upd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int r = 0; r < 4*N_CH; r++) model[r] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({ack, err, rdata, upd} !== '0) begin
            miscompares++;
            $display("FAIL reset: got ack=%b err=%b data=%h upd=%b expected all 0", ack, err, rdata, upd);
        end
        check_channels("reset");
    endtask

    task automatic test_write_read();
        bus("wr5", 1'b1, 5, 2'b11, 16'hA55A);
        vectors++;
        if (period[31:16] !== 16'hA55A) begin
            miscompares++;
            $display("FAIL period1: got %h expected a55a", period[31:16]);
        end
        bus("rd5", 1'b0, 5, 2'b00, 16'h0000);
    endtask

    task automatic test_byte_lanes();
        bus("wr5_lane0", 1'b1, 5, 2'b01, 16'h1234);
        bus("rd5_merge", 1'b0, 5, 2'b11, 16'hFFFF);
        bus("wr11", 1'b1, 11, 2'b11, 16'hFFFF);
        vectors++;
        if (dc[47:32] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL dc2: got %h expected ffff", dc[47:32]);
        end
        bus("wr2_sel0", 1'b1, 2, 2'b00, 16'hBEEF);
        bus("wr7_hi", 1'b1, 7, 2'b10, 16'h9C00);
        bus("rd7", 1'b0, 7, 2'b00, 16'h0000);
    endtask

    task automatic test_invalid();
        bus("wr12", 1'b1, 12, 2'b11, 16'hDEAD);
        bus("rd17", 1'b0, 17, 2'b11, 16'h0000);
        bus("rd_ffff", 1'b0, 16'hFFFF, 2'b11, 16'h0000);
        bus("rd11_last", 1'b0, 11, 2'b00, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'(5); sel = 2'b00;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.ack  = (i % 2 == 0);
            e.err  = 1'b0;
            e.data = e.ack ? model[5] : '0;
            e.upd  = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
            pop_compare("held_stb");
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (acks !== 3) begin
            miscompares++;
            $display("FAIL held_stb_count: got %0d acks expected 3", acks);
        end
    endtask

    task automatic test_reset_priority();
        rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = '0; sel = 2'b11; wdata = 16'h1234;
        for (int r = 0; r < 4*N_CH; r++) model[r] = '0;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        vectors++;
        if ({ack, err, ctrl[15:0]} !== '0) begin
            miscompares++;
            $display("FAIL rst_prio: got ack=%b err=%b ctrl0=%h expected 0/0/0000", ack, err, ctrl[15:0]);
        end
        check_channels("rst_prio");
    endtask

    task automatic test_lock();
        bus("lock_set", 1'b1, 0, 2'b11, 16'h8000);
        bus("lock_wr1", 1'b1, 1, 2'b11, 16'h0042);
        bus("lock_wr5", 1'b1, 5, 2'b11, 16'h0777);
        bus("lock_clr", 1'b1, 0, 2'b11, 16'h0000);
        bus("unlock_wr1", 1'b1, 1, 2'b11, 16'h0042);
        vectors++;
        if (period[15:0] !== 16'h0042) begin
            miscompares++;
            $display("FAIL period0: got %h expected 0042", period[15:0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_invalid();
        test_back_to_back();
        test_reset_priority();
        test_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
